// File: rtl/bsg_mux_segmented_pipe_if.sv
// Handshake/data bundle for bsg_mux_segmented_pipe.
//   data_i     : els_p packed input words, word k at [k*width_lp +: width_lp]
//   sel_i      : per-segment word select, segment s at [s*sel_width_lp +: sel_width_lp]
//   sel_hold_i : 1 = use the held select register, 0 = use sel_i
//   v_i/ready_o: ready/valid input handshake
//   data_o/v_o : head-of-buffer word and its valid
//   yumi_i     : consumer takes data_o this cycle (only while v_o=1)
interface bsg_mux_segmented_pipe_if #(
    parameter int unsigned segments_p      = 16,
    parameter int unsigned segment_width_p = 1,
    parameter int unsigned els_p           = 2
);
    localparam int unsigned width_lp     = segments_p * segment_width_p;
    localparam int unsigned sel_width_lp = ($clog2(els_p) > 1) ? $clog2(els_p) : 1;

    logic [els_p*width_lp-1:0]      data_i;
    logic [segments_p*sel_width_lp-1:0] sel_i;
    logic                           sel_hold_i;
    logic                           v_i;
    logic                           ready_o;
    logic [width_lp-1:0]            data_o;
    logic                           v_o;
    logic                           yumi_i;

    // Producer/consumer side (testbench or upstream/downstream logic).
    modport master (
        output data_i, sel_i, sel_hold_i, v_i, yumi_i,
        input  ready_o, data_o, v_o
    );

    // Design side.
    modport slave (
        input  data_i, sel_i, sel_hold_i, v_i, yumi_i,
        output ready_o, data_o, v_o
    );
endinterface

// File: rtl/bsg_mux_segmented_pipe.sv
// Pipelined segmented mux: each segment independently picks one of els_p
// input words (live or sticky select), result stored in a 2-entry skid
// buffer with ready/valid in and valid/yumi out.
//   clk_i     : clock, all state on rising edge
//   reset_n_i : asynchronous active-low reset
//   bus       : bsg_mux_segmented_pipe_if slave modport (data/select/handshake)
module bsg_mux_segmented_pipe #(
    parameter int unsigned segments_p      = 16,
    parameter int unsigned segment_width_p = 1,
    parameter int unsigned els_p           = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    bsg_mux_segmented_pipe_if.slave      bus
);
    localparam int unsigned width_lp     = segments_p * segment_width_p;
    localparam int unsigned sel_width_lp = ($clog2(els_p) > 1) ? $clog2(els_p) : 1;
    localparam int unsigned sel_bits_lp  = segments_p * sel_width_lp;

    logic [sel_bits_lp-1:0]  held_sel_r, held_sel_n, eff_sel_c;
    logic [sel_width_lp-1:0] seg_sel_c;
    logic [width_lp-1:0]     mux_c;
    logic [width_lp-1:0]     head_r, head_n, tail_r, tail_n;
    logic [1:0]              count_r, count_n;
    logic                    v_r, ready_r;
    logic                    accept_c, deq_c;

    // Illegal yumi with nothing valid is ignored.
    assign accept_c  = bus.v_i & ready_r;
    assign deq_c     = bus.yumi_i & v_r;
    assign eff_sel_c = bus.sel_hold_i ? held_sel_r : bus.sel_i;

    // Per-segment word select; out-of-range selects leave the segment zero.
    always_comb begin
        mux_c     = '0;
        seg_sel_c = '0;
        for (int unsigned s = 0; s < segments_p; s++) begin
            seg_sel_c = eff_sel_c[s*sel_width_lp +: sel_width_lp];
            for (int unsigned k = 0; k < els_p; k++) begin
                if (seg_sel_c == sel_width_lp'(k)) begin
                    mux_c[s*segment_width_p +: segment_width_p] =
                        bus.data_i[k*width_lp + s*segment_width_p +: segment_width_p];
                end
            end
        end
    end

    // Next-state: head_r is always the oldest entry, tail_r only valid at count 2.
    always_comb begin
        head_n     = head_r;
        tail_n     = tail_r;
        count_n    = count_r;
        held_sel_n = held_sel_r;

        if (accept_c && !bus.sel_hold_i) begin
            held_sel_n = bus.sel_i;
        end

        case (count_r)
            2'd0: begin
                if (accept_c) begin
                    head_n  = mux_c;
                    count_n = 2'd1;
                end
            end
            2'd1: begin
                if (accept_c && deq_c) begin
                    head_n = mux_c;
                end else if (accept_c) begin
                    tail_n  = mux_c;
                    count_n = 2'd2;
                end else if (deq_c) begin
                    count_n = 2'd0;
                end
            end
            default: begin
                // Full: ready_r is low, so only a dequeue can happen.
                if (deq_c) begin
                    head_n  = tail_r;
                    count_n = 2'd1;
                end
            end
        endcase
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            held_sel_r <= '0;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= 2'd0;
            v_r        <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            held_sel_r <= held_sel_n;
            head_r     <= head_n;
            tail_r     <= tail_n;
            count_r    <= count_n;
            v_r        <= (count_n != 2'd0);
            ready_r    <= (count_n != 2'd2);
        end
    end

    assign bus.data_o  = head_r;
    assign bus.v_o     = v_r;
    assign bus.ready_o = ready_r;
endmodule

// File: tb/tb_bsg_mux_segmented_pipe.sv
// Self-checking bench: instance A (4 segments x 4 bits, 3 words) for mux,
// sticky select, streaming and async reset; instance B (defaults) for
// backpressure.
module tb_bsg_mux_segmented_pipe;
    logic clk;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    bsg_mux_segmented_pipe_if #(.segments_p(4), .segment_width_p(4), .els_p(3)) bus_a ();
    bsg_mux_segmented_pipe_if bus_b ();

    bsg_mux_segmented_pipe #(.segments_p(4), .segment_width_p(4), .els_p(3)) dut_a (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus_a)
    );

    bsg_mux_segmented_pipe dut_b (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [47:0] data;
        logic [7:0]  sel;
        logic        hold;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl [6];
    logic [15:0] q_a [$];
    logic [15:0] exp_next_a;
    logic [7:0]  held_m;
    int          pops_a;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: segment s takes nibble s of word sel[s], zero if sel[s]==3.
    function automatic logic [15:0] model_a(input logic [47:0] d, input logic [7:0] s);
        logic [15:0] r;
        logic [1:0]  f;
        r = '0;
        for (int seg = 0; seg < 4; seg++) begin
            f = s[seg*2 +: 2];
            if (f < 2'd3) r[seg*4 +: 4] = d[int'(f)*16 + seg*4 +: 4];
        end
        return r;
    endfunction

    // Called at a negedge after inputs are set: scoreboard bookkeeping for the
    // coming posedge, then advance to the next negedge.
    task automatic commit_a();
        logic [15:0] e;
        if (bus_a.yumi_i) begin
            if (!bus_a.v_o) begin
                checks++;
                errors++;
                $display("FAIL yumi_without_v: yumi_i=1 while v_o=0 (t=%0t)", $time);
            end else if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: output %h with empty scoreboard", bus_a.data_o);
            end else begin
                e = q_a.pop_front();
                check16("sb_data", bus_a.data_o, e);
                pops_a++;
            end
        end
        if (bus_a.v_i && bus_a.ready_o) q_a.push_back(exp_next_a);
        @(negedge clk);
    endtask

    task automatic idle_a();
        bus_a.data_i     = '0;
        bus_a.sel_i      = '0;
        bus_a.sel_hold_i = 1'b0;
        bus_a.v_i        = 1'b0;
        bus_a.yumi_i     = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_a();
        q_a.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1'b0, 48'h3333_2222_1111, 8'hE4, 1'b0, 16'h0321};
        tbl[1] = '{1'b0, 48'h3333_2222_1111, 8'hAA, 1'b0, 16'h3333};
        tbl[2] = '{1'b0, 48'h3333_2222_1111, 8'h00, 1'b1, 16'h3333};
        tbl[3] = '{1'b1, 48'h3333_2222_1111, 8'hAA, 1'b1, 16'h1111};
        tbl[4] = '{1'b0, 48'h3333_2222_1111, 8'h55, 1'b0, 16'h2222};
        tbl[5] = '{1'b0, 48'hCCCC_BBBB_AAAA, 8'h00, 1'b1, 16'hBBBB};

        reset_n = 1'b0;
        exp_next_a = '0;
        held_m = '0;
        pops_a = 0;
        idle_a();
        bus_b.data_i     = '0;
        bus_b.sel_i      = '0;
        bus_b.sel_hold_i = 1'b0;
        bus_b.v_i        = 1'b0;
        bus_b.yumi_i     = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check1 ("rst_v_a",     bus_a.v_o,     1'b0);
        check16("rst_data_a",  bus_a.data_o,  16'h0000);
        check1 ("rst_ready_a", bus_a.ready_o, 1'b0);
        check1 ("rst_v_b",     bus_b.v_o,     1'b0);
        check1 ("rst_ready_b", bus_b.ready_o, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check1("rel_ready_a", bus_a.ready_o, 1'b1);
        check1("rel_ready_b", bus_b.ready_o, 1'b1);

        // Table: basic mux and sticky select.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].rst_before) do_reset();
            bus_a.data_i     = tbl[i].data;
            bus_a.sel_i      = tbl[i].sel;
            bus_a.sel_hold_i = tbl[i].hold;
            bus_a.v_i        = 1'b1;
            bus_a.yumi_i     = 1'b0;
            exp_next_a       = tbl[i].exp;
            commit_a();
            bus_a.v_i = 1'b0;
            check1 ("tbl_v",    bus_a.v_o,    1'b1);
            check16("tbl_data", bus_a.data_o, tbl[i].exp);
            bus_a.yumi_i = 1'b1;
            commit_a();
            bus_a.yumi_i = 1'b0;
            check1("tbl_empty", bus_a.v_o, 1'b0);
        end

        // Backpressure on default configuration.
        bus_b.data_i = {16'hFF00, 16'h00FF};
        bus_b.sel_i  = 16'hF0F0;
        bus_b.v_i    = 1'b1;
        @(negedge clk);
        check1 ("bp_v1",     bus_b.v_o,     1'b1);
        check16("bp_data1",  bus_b.data_o,  16'hF00F);
        check1 ("bp_ready1", bus_b.ready_o, 1'b1);
        bus_b.sel_i = 16'h0F0F;
        @(negedge clk);
        check1 ("bp_ready2", bus_b.ready_o, 1'b0);
        check16("bp_data2",  bus_b.data_o,  16'hF00F);
        bus_b.sel_i = 16'hFFFF;
        @(negedge clk);
        check1 ("bp_ready3", bus_b.ready_o, 1'b0);
        check16("bp_data3",  bus_b.data_o,  16'hF00F);
        bus_b.yumi_i = 1'b1;
        @(negedge clk);
        bus_b.yumi_i = 1'b0;
        bus_b.v_i    = 1'b0;
        check1 ("bp_ready4", bus_b.ready_o, 1'b1);
        check1 ("bp_v4",     bus_b.v_o,     1'b1);
        check16("bp_order",  bus_b.data_o,  16'h0FF0);
        bus_b.yumi_i = 1'b1;
        @(negedge clk);
        bus_b.yumi_i = 1'b0;
        check1 ("bp_empty_v", bus_b.v_o,    1'b0);
        check16("bp_hold",    bus_b.data_o, 16'h0FF0);

        // Streaming with random data/selects, yumi follows v_o.
        do_reset();
        held_m = '0;
        pops_a = 0;
        for (int i = 0; i < 100; i++) begin
            bus_a.data_i     = {16'($urandom), 16'($urandom), 16'($urandom)};
            bus_a.sel_i      = 8'($urandom);
            bus_a.sel_hold_i = ($urandom_range(0, 3) == 0);
            bus_a.v_i        = 1'b1;
            bus_a.yumi_i     = bus_a.v_o;
            exp_next_a = model_a(bus_a.data_i, bus_a.sel_hold_i ? held_m : bus_a.sel_i);
            if (!bus_a.sel_hold_i) held_m = bus_a.sel_i;
            check1("stream_ready", bus_a.ready_o, 1'b1);
            commit_a();
        end
        checks++;
        if (pops_a != 99) begin
            errors++;
            $display("FAIL stream_rate: got %0d outputs expected 99", pops_a);
        end
        bus_a.v_i = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (q_a.size() == 0) break;
            bus_a.yumi_i = bus_a.v_o;
            commit_a();
        end
        bus_a.yumi_i = 1'b0;
        checks++;
        if (q_a.size() != 0 || pops_a != 100) begin
            errors++;
            $display("FAIL stream_drain: got %0d outputs, %0d left, expected 100 and 0",
                     pops_a, q_a.size());
        end

        // Async reset with two entries buffered.
        bus_a.data_i = 48'h3333_2222_1111;
        bus_a.sel_i  = 8'h55;
        bus_a.v_i    = 1'b1;
        exp_next_a   = 16'h2222;
        commit_a();
        commit_a();
        bus_a.v_i = 1'b0;
        check1("full_ready", bus_a.ready_o, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check1 ("async_v",     bus_a.v_o,     1'b0);
        check1 ("async_ready", bus_a.ready_o, 1'b0);
        check16("async_data",  bus_a.data_o,  16'h0000);
        q_a.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check1("no_stale_v", bus_a.v_o, 1'b0);
        end
        check1("post_rst_ready", bus_a.ready_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
